sw_test_status_mon: RTL and testbench

Multi-channel software test-status monitor for simulation tops. It snoops write traffic from NumChans software agents (cores or sim SRAM windows), tracks per-channel test state and decides global pass/fail/timeout. It also buffers console bytes written to a log address into a FIFO for the testbench to drain. This is the parametrised successor of the single-channel status interface: it adds multiple channels, a completion policy, a watchdog and buffered logging.

---
 rtl/sw_test_status_pkg.sv | 32 +++
 rtl/sw_test_status_mon_if.sv | 31 +++
 rtl/prim_fifo_sync.sv | 54 +++++
 rtl/sw_test_status_chan.sv | 37 +++
 rtl/sw_test_status_mon.sv | 136 +++++++++++++
 tb/tb_sw_test_status_mon.sv | 234 +++++++++++++++++++++++
 6 files changed

// File: rtl/sw_test_status_pkg.sv
// Shared types for the software test-status monitor: status codes, channel
// states and the log FIFO entry layout.
package sw_test_status_pkg;

  typedef enum logic [15:0] {
    StatusInTest = 16'h4354,
    StatusInWfi  = 16'h1d1e,
    StatusPassed = 16'h900d,
    StatusFailed = 16'hbaad,
    StatusBoot   = 16'hb090
  } sw_test_status_e;

  typedef enum logic [2:0] {
    ChanBoot   = 3'd0,
    ChanInTest = 3'd1,
    ChanInWfi  = 3'd2,
    ChanPassed = 3'd3,
    ChanFailed = 3'd4
  } chan_state_e;

  typedef struct packed {
    logic [2:0] chan;
    logic [7:0] data;
  } log_entry_t;

  localparam int unsigned LogAddrOffset = 4;

  function automatic logic is_terminal(input chan_state_e state);
    return (state == ChanPassed) || (state == ChanFailed);
  endfunction

endpackage

// File: rtl/sw_test_status_mon_if.sv
// Snoop/log bundle between the software agents, the testbench log drain and
// the status monitor.
interface sw_test_status_mon_if #(
  parameter int unsigned NumChans = 2,
  parameter int unsigned AddrW    = 32
);
  logic [NumChans-1:0]            wr_valid_i;
  logic [NumChans-1:0][AddrW-1:0] wr_addr_i;
  logic [NumChans-1:0][15:0]      wr_data_i;
  logic [NumChans-1:0][2:0]       chan_state_o;
  logic                           test_done_o;
  logic                           test_passed_o;
  logic                           timeout_o;
  logic                           log_valid_o;
  logic [7:0]                     log_data_o;
  logic [2:0]                     log_chan_o;
  logic                           log_ready_i;
  logic                           log_dropped_o;

  modport master (
    output wr_valid_i, wr_addr_i, wr_data_i, log_ready_i,
    input  chan_state_o, test_done_o, test_passed_o, timeout_o,
           log_valid_o, log_data_o, log_chan_o, log_dropped_o
  );

  modport slave (
    input  wr_valid_i, wr_addr_i, wr_data_i, log_ready_i,
    output chan_state_o, test_done_o, test_passed_o, timeout_o,
           log_valid_o, log_data_o, log_chan_o, log_dropped_o
  );
endinterface

// File: rtl/prim_fifo_sync.sv
// Synchronous FIFO with optional empty pass-through; a full FIFO still
// accepts a write in the same cycle as a read.
module prim_fifo_sync #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  parameter bit          Pass  = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  input  logic [Width-1:0] wdata_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o
);
  localparam int unsigned PtrW   = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = (PtrW+1)'(1);

  logic [Width-1:0] storage_r [Depth];
  logic [PtrW:0]    wptr_r, rptr_r;
  logic             empty_s, full_s, pass_s, push_s, pop_s;

  assign empty_s  = (wptr_r == rptr_r);
  assign full_s   = (wptr_r[PtrW] != rptr_r[PtrW]) &&
                    (wptr_r[PtrW-1:0] == rptr_r[PtrW-1:0]);
  assign pass_s   = Pass && empty_s && wvalid_i && rready_i;
  assign wready_o = !full_s || rready_i;
  assign rvalid_o = !empty_s || (Pass && wvalid_i);
  assign rdata_o  = (Pass && empty_s) ? wdata_i : storage_r[rptr_r[PtrW-1:0]];
  assign push_s   = wvalid_i && wready_o && !pass_s;
  assign pop_s    = rready_i && !empty_s;

  // Pointer and storage update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_r <= '0;
      rptr_r <= '0;
      for (int i = 0; i < int'(Depth); i++) storage_r[i] <= '0;
    end else if (clr_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (push_s) begin
        storage_r[wptr_r[PtrW-1:0]] <= wdata_i;
        wptr_r <= wptr_r + PtrOne;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PtrOne;
      end
    end
  end
endmodule

// File: rtl/sw_test_status_chan.sv
// Per-channel test-state tracker driven by status-code writes.
module sw_test_status_chan
  import sw_test_status_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        status_wr_i,
  input  logic [15:0] status_data_i,
  output chan_state_e state_o
);
  chan_state_e state_r, state_s;

  // Next state: Passed/Failed absorb, unknown codes leave the state alone
  always_comb begin
    state_s = state_r;
    if (status_wr_i && !is_terminal(state_r)) begin
      case (status_data_i)
        StatusBoot:   state_s = ChanBoot;
        StatusInTest: state_s = ChanInTest;
        StatusInWfi:  state_s = ChanInWfi;
        StatusPassed: state_s = ChanPassed;
        StatusFailed: state_s = ChanFailed;
        default:      state_s = state_r;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_r <= ChanBoot;
    else         state_r <= state_s;
  end

  assign state_o = state_r;
endmodule

// File: rtl/sw_test_status_mon.sv
// Multi-channel software test-status monitor: per-channel state, global
// verdict with optional watchdog, and a buffered console log.
module sw_test_status_mon
  import sw_test_status_pkg::*;
#(
  parameter int unsigned     NumChans      = 2,
  parameter int unsigned     AddrW         = 32,
  parameter logic [AddrW-1:0] StatusAddr   = 32'h1000_0000,
  parameter bit              RequireAll    = 1'b1,
  parameter int unsigned     TimeoutCycles = 0,
  parameter int unsigned     LogDepth      = 16
) (
  input logic clk_i,
  input logic rst_ni,
  sw_test_status_mon_if.slave bus
);
  localparam logic [AddrW-1:0] LogAddr = StatusAddr + AddrW'(LogAddrOffset);

  chan_state_e         chan_state_s [NumChans];
  logic [NumChans-1:0] status_hit_s, log_hit_s;
  logic                done_r, passed_r, timeout_r, dropped_r;
  logic                any_failed_s, all_passed_s, any_passed_s, pass_cond_s;
  logic                expire_s;

  for (genvar c = 0; c < NumChans; c++) begin : g_chan
    assign status_hit_s[c] = bus.wr_valid_i[c] && (bus.wr_addr_i[c] == StatusAddr);
    assign log_hit_s[c]    = bus.wr_valid_i[c] && (bus.wr_addr_i[c] == LogAddr);

    sw_test_status_chan u_chan (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .status_wr_i  (status_hit_s[c]),
      .status_data_i(bus.wr_data_i[c]),
      .state_o      (chan_state_s[c])
    );
    assign bus.chan_state_o[c] = chan_state_s[c];
  end

  // Reduce channel states into the completion conditions
  always_comb begin
    any_failed_s = 1'b0;
    all_passed_s = 1'b1;
    any_passed_s = 1'b0;
    for (int c = 0; c < int'(NumChans); c++) begin
      any_failed_s = any_failed_s | (chan_state_s[c] == ChanFailed);
      all_passed_s = all_passed_s & (chan_state_s[c] == ChanPassed);
      any_passed_s = any_passed_s | (chan_state_s[c] == ChanPassed);
    end
    pass_cond_s = RequireAll ? all_passed_s : any_passed_s;
  end

  if (TimeoutCycles > 0) begin : g_wdog
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] cnt_r;

    // Saturating watchdog that stops once a verdict exists
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                     cnt_r <= '0;
      else if (!done_r && cnt_r != '1) cnt_r <= cnt_r + CntW'(1);
      else                             cnt_r <= cnt_r;
    end
    assign expire_s = !done_r && (cnt_r == CntW'(TimeoutCycles - 1));
  end else begin : g_no_wdog
    assign expire_s = 1'b0;
  end

  // Verdict: Failed first, then completion, then watchdog; frozen once done
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_r    <= 1'b0;
      passed_r  <= 1'b0;
      timeout_r <= 1'b0;
    end else if (!done_r) begin
      if (any_failed_s) begin
        done_r   <= 1'b1;
        passed_r <= 1'b0;
      end else if (pass_cond_s) begin
        done_r   <= 1'b1;
        passed_r <= 1'b1;
      end else if (expire_s) begin
        done_r    <= 1'b1;
        passed_r  <= 1'b0;
        timeout_r <= 1'b1;
      end
    end
  end

  logic       push_s, multi_s, fifo_wready_s;
  log_entry_t push_data_s, head_s;

  // Lowest-index logging channel wins the single push slot
  always_comb begin
    push_s      = 1'b0;
    multi_s     = 1'b0;
    push_data_s = '0;
    for (int c = 0; c < int'(NumChans); c++) begin
      if (log_hit_s[c] && push_s) begin
        multi_s = 1'b1;
      end else if (log_hit_s[c]) begin
        push_s      = 1'b1;
        push_data_s = '{chan: 3'(c), data: bus.wr_data_i[c][7:0]};
      end else begin
        push_s = push_s;
      end
    end
  end

  // Sticky record of any lost log byte
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) dropped_r <= 1'b0;
    else         dropped_r <= dropped_r | multi_s | (push_s & ~fifo_wready_s);
  end

  prim_fifo_sync #(
    .Width($bits(log_entry_t)),
    .Depth(LogDepth),
    .Pass (1'b0)
  ) u_log_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (1'b0),
    .wvalid_i(push_s),
    .wready_o(fifo_wready_s),
    .wdata_i (push_data_s),
    .rvalid_o(bus.log_valid_o),
    .rready_i(bus.log_ready_i),
    .rdata_o (head_s)
  );

  assign bus.log_data_o    = head_s.data;
  assign bus.log_chan_o    = head_s.chan;
  assign bus.log_dropped_o = dropped_r;
  assign bus.test_done_o   = done_r;
  assign bus.test_passed_o = passed_r;
  assign bus.timeout_o     = timeout_r;
endmodule

// File: tb/tb_sw_test_status_mon.sv
// Directed bench for sw_test_status_mon: dut_a (RequireAll, no watchdog,
// 4-deep log) and dut_b (any-pass, 100-cycle watchdog).
module tb_sw_test_status_mon;
  import sw_test_status_pkg::*;

  localparam logic [31:0] SA = 32'h1000_0000;
  localparam logic [31:0] LA = 32'h1000_0004;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sw_test_status_mon_if #(.NumChans(2), .AddrW(32)) ifa ();
  sw_test_status_mon_if #(.NumChans(2), .AddrW(32)) ifb ();

  sw_test_status_mon #(.NumChans(2), .AddrW(32), .StatusAddr(SA), .RequireAll(1'b1),
    .TimeoutCycles(0), .LogDepth(4)) dut_a (.clk_i(clk), .rst_ni(rst_a), .bus(ifa));
  sw_test_status_mon #(.NumChans(2), .AddrW(32), .StatusAddr(SA), .RequireAll(1'b0),
    .TimeoutCycles(100), .LogDepth(16)) dut_b (.clk_i(clk), .rst_ni(rst_b), .bus(ifb));

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] addr0, addr1;
    logic [15:0] d0, d1;
    chan_state_e s0, s1;
    logic        done, passed;
  } vec_t;
  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_a();
    ifa.wr_valid_i = '0; ifa.wr_addr_i = '0; ifa.wr_data_i = '0;
  endtask

  task automatic clear_b();
    ifb.wr_valid_i = '0; ifb.wr_addr_i = '0; ifb.wr_data_i = '0;
  endtask

  task automatic wr_a(input int ch, input logic [31:0] addr, input logic [15:0] data);
    ifa.wr_valid_i[ch] = 1'b1; ifa.wr_addr_i[ch] = addr; ifa.wr_data_i[ch] = data;
  endtask

  task automatic wr_b(input int ch, input logic [31:0] addr, input logic [15:0] data);
    ifb.wr_valid_i[ch] = 1'b1; ifb.wr_addr_i[ch] = addr; ifb.wr_data_i[ch] = data;
  endtask

  task automatic reset_a();
    clear_a(); ifa.log_ready_i = 1'b0; rst_a = 1'b0;
    tick(); tick(); rst_a = 1'b1;
  endtask

  task automatic reset_b();
    clear_b(); ifb.log_ready_i = 1'b0; rst_b = 1'b0;
    tick(); tick(); rst_b = 1'b1;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_st0"}, 32'(ifa.chan_state_o[0]), 32'(ChanBoot));
    check({tag, "_st1"}, 32'(ifa.chan_state_o[1]), 32'(ChanBoot));
    check({tag, "_done"}, 32'(ifa.test_done_o), 32'd0);
    check({tag, "_passed"}, 32'(ifa.test_passed_o), 32'd0);
    check({tag, "_timeout"}, 32'(ifa.timeout_o), 32'd0);
    check({tag, "_lvalid"}, 32'(ifa.log_valid_o), 32'd0);
    check({tag, "_ldata"}, 32'(ifa.log_data_o), 32'd0);
    check({tag, "_lchan"}, 32'(ifa.log_chan_o), 32'd0);
    check({tag, "_ldrop"}, 32'(ifa.log_dropped_o), 32'd0);
  endtask

  task automatic check_log_a(input string tag, input logic [7:0] data, input logic [2:0] ch);
    check({tag, "_valid"}, 32'(ifa.log_valid_o), 32'd1);
    check({tag, "_data"}, 32'(ifa.log_data_o), 32'(data));
    check({tag, "_chan"}, 32'(ifa.log_chan_o), 32'(ch));
  endtask

  initial begin
    vecs[0] = '{2'b01, SA, SA, 16'h4354, 16'h0000, ChanInTest, ChanBoot,   1'b0, 1'b0};
    vecs[1] = '{2'b11, SA, SA, 16'h1234, 16'h1d1e, ChanInTest, ChanInWfi,  1'b0, 1'b0};
    vecs[2] = '{2'b11, SA, SA, 16'hb090, 16'h4354, ChanBoot,   ChanInTest, 1'b0, 1'b0};
    vecs[3] = '{2'b11, SA, SA + 32'd8, 16'h900d, 16'hbaad, ChanPassed, ChanInTest, 1'b0, 1'b0};
    vecs[4] = '{2'b11, SA, SA, 16'hbaad, 16'h1d1e, ChanPassed, ChanInWfi,  1'b0, 1'b0};
    vecs[5] = '{2'b10, SA, SA, 16'h0000, 16'h900d, ChanPassed, ChanPassed, 1'b1, 1'b1};
    vecs[6] = '{2'b10, SA, SA, 16'h0000, 16'hbaad, ChanPassed, ChanPassed, 1'b1, 1'b1};

    reset_a();
    reset_b();
    check_reset_a("rst");
    check("rst_b_timeout", 32'(ifb.timeout_o), 32'd0);

    // Cumulative state-machine vectors on dut_a
    for (int i = 0; i < 7; i++) begin
      ifa.wr_valid_i   = vecs[i].valid;
      ifa.wr_addr_i[0] = vecs[i].addr0;
      ifa.wr_addr_i[1] = vecs[i].addr1;
      ifa.wr_data_i[0] = vecs[i].d0;
      ifa.wr_data_i[1] = vecs[i].d1;
      tick();
      clear_a();
      tick();
      check($sformatf("vec%0d_st0", i), 32'(ifa.chan_state_o[0]), 32'(vecs[i].s0));
      check($sformatf("vec%0d_st1", i), 32'(ifa.chan_state_o[1]), 32'(vecs[i].s1));
      check($sformatf("vec%0d_done", i), 32'(ifa.test_done_o), 32'(vecs[i].done));
      check($sformatf("vec%0d_passed", i), 32'(ifa.test_passed_o), 32'(vecs[i].passed));
    end

    // Done exactly two cycles after the last required Passed write
    reset_a();
    wr_a(0, SA, 16'h4354); tick();
    wr_a(0, SA, 16'h900d); tick(); clear_a();
    repeat (9) tick();
    check("t1_done_before", 32'(ifa.test_done_o), 32'd0);
    wr_a(1, SA, 16'h900d); tick(); clear_a();
    check("t1_done_plus1", 32'(ifa.test_done_o), 32'd0);
    tick();
    check("t1_done_plus2", 32'(ifa.test_done_o), 32'd1);
    check("t1_passed", 32'(ifa.test_passed_o), 32'd1);

    // Simultaneous Passed and Failed: Failed wins and the verdict freezes
    reset_a();
    wr_a(0, SA, 16'h900d); wr_a(1, SA, 16'hbaad); tick(); clear_a();
    check("t2_st0", 32'(ifa.chan_state_o[0]), 32'(ChanPassed));
    check("t2_st1", 32'(ifa.chan_state_o[1]), 32'(ChanFailed));
    tick();
    check("t2_done", 32'(ifa.test_done_o), 32'd1);
    check("t2_passed", 32'(ifa.test_passed_o), 32'd0);
    wr_a(1, SA, 16'h900d); tick(); clear_a(); tick();
    check("t2_st1_late", 32'(ifa.chan_state_o[1]), 32'(ChanFailed));
    check("t2_passed_late", 32'(ifa.test_passed_o), 32'd0);

    // Watchdog expiry at cycle 100 after reset release
    reset_b();
    repeat (99) tick();
    check("t3_timeout_99", 32'(ifb.timeout_o), 32'd0);
    check("t3_done_99", 32'(ifb.test_done_o), 32'd0);
    tick();
    check("t3_timeout_100", 32'(ifb.timeout_o), 32'd1);
    check("t3_done_100", 32'(ifb.test_done_o), 32'd1);
    check("t3_passed_100", 32'(ifb.test_passed_o), 32'd0);

    // Completion landing on the expiry cycle beats the watchdog
    reset_b();
    repeat (98) tick();
    wr_b(0, SA, 16'h900d); wr_b(1, SA, 16'h900d); tick(); clear_b();
    check("t3b_done_99", 32'(ifb.test_done_o), 32'd0);
    tick();
    check("t3b_done_100", 32'(ifb.test_done_o), 32'd1);
    check("t3b_passed_100", 32'(ifb.test_passed_o), 32'd1);
    check("t3b_timeout_100", 32'(ifb.timeout_o), 32'd0);
    repeat (5) tick();
    check("t3b_timeout_105", 32'(ifb.timeout_o), 32'd0);

    // Overfill a 4-deep log, then drain
    reset_a();
    for (int i = 0; i < 5; i++) begin
      wr_a(0, LA, 16'(8'h41 + i)); tick();
    end
    clear_a();
    check("t4_dropped", 32'(ifa.log_dropped_o), 32'd1);
    ifa.log_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_log_a($sformatf("t4_pop%0d", i), 8'(8'h41 + i), 3'd0);
      tick();
    end
    ifa.log_ready_i = 1'b0;
    check("t4_empty", 32'(ifa.log_valid_o), 32'd0);

    // Push and pop together while full are both accepted
    reset_a();
    for (int i = 0; i < 4; i++) begin
      wr_a(0, LA, 16'(8'h57 + i)); tick();
    end
    wr_a(0, LA, 16'h0051); ifa.log_ready_i = 1'b1; tick();
    clear_a(); ifa.log_ready_i = 1'b0;
    check("t4b_dropped", 32'(ifa.log_dropped_o), 32'd0);
    ifa.log_ready_i = 1'b1;
    check_log_a("t4b_pop0", 8'h58, 3'd0); tick();
    check_log_a("t4b_pop1", 8'h59, 3'd0); tick();
    check_log_a("t4b_pop2", 8'h5a, 3'd0); tick();
    check_log_a("t4b_pop3", 8'h51, 3'd0); tick();
    ifa.log_ready_i = 1'b0;
    check("t4b_empty", 32'(ifa.log_valid_o), 32'd0);

    // Same-cycle logging: lowest channel wins
    reset_a();
    wr_a(0, LA, 16'h0031); wr_a(1, LA, 16'h0032); tick(); clear_a();
    check_log_a("t5_head", 8'h31, 3'd0);
    check("t5_dropped", 32'(ifa.log_dropped_o), 32'd1);
    ifa.log_ready_i = 1'b1; tick(); ifa.log_ready_i = 1'b0;
    check("t5_empty", 32'(ifa.log_valid_o), 32'd0);
    wr_a(1, LA, 16'h0055); tick(); clear_a();
    check_log_a("t5_ch1", 8'h55, 3'd1);

    // Asynchronous reset mid-test on both instances
    reset_a();
    reset_b();
    wr_a(0, SA, 16'h900d); wr_b(0, SA, 16'h900d); tick(); clear_a(); clear_b();
    wr_a(0, LA, 16'h0077); wr_a(1, LA, 16'h0078); tick(); clear_a();
    check("t6_pre_st0", 32'(ifa.chan_state_o[0]), 32'(ChanPassed));
    check("t6_pre_b_done", 32'(ifb.test_done_o), 32'd1);
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    check_reset_a("t6");
    check("t6_b_st0", 32'(ifb.chan_state_o[0]), 32'(ChanBoot));
    check("t6_b_done", 32'(ifb.test_done_o), 32'd0);
    check("t6_b_passed", 32'(ifb.test_passed_o), 32'd0);
    tick();
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (99) tick();
    check("t6_wdog_99", 32'(ifb.timeout_o), 32'd0);
    tick();
    check("t6_wdog_100", 32'(ifb.timeout_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
